// File: rtl/bram_rdback_checker.sv
// bram_rdback_checker
//   Consumes the BRAM controller's read-back stream and checks every beat
//   against the write pattern (data = beat index mod 2^DATA_WIDTH). It
//   counts beats and mismatches. At the end of a run it pulses o_done for
//   one cycle and holds the pass/fail verdict, the timeout flag and the
//   counts.
//
//   Optional feature macro: BRAM_CHK_FIRST_ERR_EN
//     When defined, the index and data of the first mismatching beat of a
//     run are captured on o_ferr_vld / o_ferr_idx / o_ferr_data.
//
//   Ports
//     clk, rst      clock and synchronous active-high reset
//     i_start       arm the checker (sampled in IDLE only)
//     i_cnt         expected beat count, latched on an accepted start
//     i_valid       read-data beat strobe
//     i_data        read-data beat
//     o_busy        high while checking
//     o_done        one-cycle end-of-run pulse
//     o_pass        verdict, held until the next accepted start
//     o_timeout     watchdog fired in the last run, held
//     o_overrun     sticky: a beat arrived outside CHECK
//     o_rx_cnt      beats accepted in the current or last run
//     o_err_cnt     mismatching beats, saturating
//     o_ferr_*      first-error capture (macro builds only)
module bram_rdback_checker #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 12,
   parameter int TIMEOUT    = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_cnt,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_pass,
   output logic                  o_timeout,
   output logic                  o_overrun,
   output logic [ADDR_WIDTH-1:0] o_rx_cnt,
   output logic [ADDR_WIDTH-1:0] o_err_cnt
`ifdef BRAM_CHK_FIRST_ERR_EN
   ,
   output logic                  o_ferr_vld,
   output logic [ADDR_WIDTH-1:0] o_ferr_idx,
   output logic [DATA_WIDTH-1:0] o_ferr_data
`endif
);

   localparam int IW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);
   localparam logic [IW-1:0]         IDLE_ONE = IW'(1);
   localparam logic [IW-1:0]         IDLE_MAX = IW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      CHECK  = 2'b01,
      REPORT = 2'b10
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [IW-1:0]         idle_cnt;

   logic                  start_ok;
   logic                  beat;
   logic                  mismatch;
   logic                  last_beat;
   logic                  wd_fire;
   logic [DATA_WIDTH-1:0] expected;

   // Size cast truncates the index, or zero-extends it when the data is wider.
   assign expected  = DATA_WIDTH'(o_rx_cnt);
   assign start_ok  = (state_q == IDLE) && i_start && (i_cnt != '0);
   assign beat      = (state_q == CHECK) && i_valid;
   assign mismatch  = beat && (i_data != expected);
   assign last_beat = beat && (o_rx_cnt == (r_cnt - CNT_ONE));
   assign wd_fire   = (state_q == CHECK) && !i_valid && (idle_cnt == IDLE_MAX);

   assign o_busy = (state_q == CHECK);
   assign o_done = (state_q == REPORT);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = IDLE;
      unique case (state_q)
         IDLE:    state_d = start_ok ? CHECK : IDLE;
         CHECK:   state_d = (last_beat || wd_fire) ? REPORT : CHECK;
         REPORT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         idle_cnt  <= '0;
         o_rx_cnt  <= '0;
         o_err_cnt <= '0;
         o_pass    <= 1'b0;
         o_timeout <= 1'b0;
         o_overrun <= 1'b0;
      end else if (start_ok) begin
         r_cnt     <= i_cnt;
         idle_cnt  <= '0;
         o_rx_cnt  <= '0;
         o_err_cnt <= '0;
         o_pass    <= 1'b0;
         o_timeout <= 1'b0;
         // A beat coinciding with the start is dropped but still flagged.
         o_overrun <= i_valid;
      end else begin
         if (i_valid && (state_q == IDLE || state_q == REPORT))
            o_overrun <= 1'b1;
         if (state_q == CHECK) begin
            if (i_valid) begin
               idle_cnt <= '0;
               o_rx_cnt <= o_rx_cnt + CNT_ONE;
               if (mismatch && (o_err_cnt != '1))
                  o_err_cnt <= o_err_cnt + CNT_ONE;
            end else if (!wd_fire) begin
               idle_cnt <= idle_cnt + IDLE_ONE;
            end
            if (wd_fire)
               o_timeout <= 1'b1;
            // Verdict includes the final beat's comparison.
            if (last_beat || wd_fire)
               o_pass <= (o_err_cnt == '0) && !mismatch && !wd_fire;
         end
      end
   end

`ifdef BRAM_CHK_FIRST_ERR_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         o_ferr_vld  <= 1'b0;
         o_ferr_idx  <= '0;
         o_ferr_data <= '0;
      end else if (start_ok) begin
         o_ferr_vld  <= 1'b0;
         o_ferr_idx  <= '0;
         o_ferr_data <= '0;
      end else if (mismatch && !o_ferr_vld) begin
         o_ferr_vld  <= 1'b1;
         o_ferr_idx  <= o_rx_cnt;
         o_ferr_data <= i_data;
      end
   end
`else
   // No first-error capture in this build.
`endif

endmodule

// File: tb/tb_bram_rdback_checker.sv
// tb_bram_rdback_checker
//   Directed bench for bram_rdback_checker: reset state, clean run, index
//   wrap with gaps, corruption, watchdog timeout, zero count and overrun,
//   back-to-back runs, reset mid-run and the all-ones count.
module tb_bram_rdback_checker;

   localparam int DW = 8;
   localparam int AW = 12;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_start;
   logic [AW-1:0] i_cnt;
   logic          i_valid;
   logic [DW-1:0] i_data;
   logic          o_busy, o_done, o_pass, o_timeout, o_overrun;
   logic [AW-1:0] o_rx_cnt, o_err_cnt;
`ifdef BRAM_CHK_FIRST_ERR_EN
   logic          o_ferr_vld;
   logic [AW-1:0] o_ferr_idx;
   logic [DW-1:0] o_ferr_data;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   bram_rdback_checker #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .TIMEOUT   (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (i_start),
      .i_cnt      (i_cnt),
      .i_valid    (i_valid),
      .i_data     (i_data),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_pass     (o_pass),
      .o_timeout  (o_timeout),
      .o_overrun  (o_overrun),
      .o_rx_cnt   (o_rx_cnt),
      .o_err_cnt  (o_err_cnt)
`ifdef BRAM_CHK_FIRST_ERR_EN
      ,
      .o_ferr_vld (o_ferr_vld),
      .o_ferr_idx (o_ferr_idx),
      .o_ferr_data(o_ferr_data)
`endif
   );

   // Advance one clock; outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [AW-1:0] cnt);
      i_start = 1'b1;
      i_cnt   = cnt;
      tick();
      i_start = 1'b0;
   endtask

   task automatic beat(input logic [DW-1:0] d);
      i_valid = 1'b1;
      i_data  = d;
      tick();
      i_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; i_start = 1'b0; i_cnt = '0; i_valid = 1'b0; i_data = '0;
      tick(); tick();
      rst = 1'b0;
      tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", o_busy); end
      tests_run++; if (o_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", o_done); end
      tests_run++; if ({o_pass, o_timeout, o_overrun} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b want 000", {o_pass, o_timeout, o_overrun}); end
      tests_run++; if ({o_rx_cnt, o_err_cnt} !== '0) begin tests_failed++; $display("FAIL reset_counts got rx=%0d err=%0d want 0/0", o_rx_cnt, o_err_cnt); end
   endtask

   task automatic test_clean();
      logic early;
      early = 1'b0;
      start_run(12'd100);
      tests_run++; if (o_busy !== 1'b1) begin tests_failed++; $display("FAIL clean_busy got %b want 1", o_busy); end
      for (int i = 0; i < 100; i++) begin
         if (o_done) early = 1'b1;
         beat(DW'(i));
      end
      tests_run++; if (early !== 1'b0) begin tests_failed++; $display("FAIL clean_early_done got %b want 0", early); end
      tests_run++; if ({o_done, o_busy} !== 2'b10) begin tests_failed++; $display("FAIL clean_done_busy got %b want 10", {o_done, o_busy}); end
      tests_run++; if ({o_pass, o_timeout} !== 2'b10) begin tests_failed++; $display("FAIL clean_pass_to got %b want 10", {o_pass, o_timeout}); end
      tests_run++; if (o_rx_cnt !== 12'd100) begin tests_failed++; $display("FAIL clean_rx got %0d want 100", o_rx_cnt); end
      tests_run++; if (o_err_cnt !== 12'd0) begin tests_failed++; $display("FAIL clean_err got %0d want 0", o_err_cnt); end
      tick();
      tests_run++; if ({o_done, o_pass} !== 2'b01) begin tests_failed++; $display("FAIL clean_hold got done/pass=%b want 01", {o_done, o_pass}); end
   endtask

   task automatic test_wrap_gaps();
      start_run(12'd300);
      for (int i = 0; i < 300; i++) begin
         if (i > 0)
            for (int g = 0; g < 1 + (i % 3); g++) tick();
         beat(DW'(i % 256));
      end
      tests_run++; if (o_done !== 1'b1) begin tests_failed++; $display("FAIL wrap_done got %b want 1", o_done); end
      tests_run++; if ({o_pass, o_timeout} !== 2'b10) begin tests_failed++; $display("FAIL wrap_pass_to got %b want 10", {o_pass, o_timeout}); end
      tests_run++; if (o_rx_cnt !== 12'd300) begin tests_failed++; $display("FAIL wrap_rx got %0d want 300", o_rx_cnt); end
      tick();
   endtask

   task automatic test_corruption();
      logic [DW-1:0] d;
      start_run(12'd10);
      for (int i = 0; i < 10; i++) begin
         d = DW'(i);
         if (i == 3 || i == 7) d = ~d;
         beat(d);
      end
      tests_run++; if (o_done !== 1'b1) begin tests_failed++; $display("FAIL corr_done got %b want 1", o_done); end
      tests_run++; if (o_err_cnt !== 12'd2) begin tests_failed++; $display("FAIL corr_err got %0d want 2", o_err_cnt); end
      tests_run++; if (o_pass !== 1'b0) begin tests_failed++; $display("FAIL corr_pass got %b want 0", o_pass); end
      tests_run++; if (o_rx_cnt !== 12'd10) begin tests_failed++; $display("FAIL corr_rx got %0d want 10", o_rx_cnt); end
`ifdef BRAM_CHK_FIRST_ERR_EN
      tests_run++; if (o_ferr_vld !== 1'b1) begin tests_failed++; $display("FAIL corr_ferr_vld got %b want 1", o_ferr_vld); end
      tests_run++; if (o_ferr_idx !== 12'd3) begin tests_failed++; $display("FAIL corr_ferr_idx got %0d want 3", o_ferr_idx); end
      tests_run++; if (o_ferr_data !== 8'hFC) begin tests_failed++; $display("FAIL corr_ferr_data got %h want fc", o_ferr_data); end
`endif
      tick();
   endtask

   task automatic test_timeout();
      int n;
      start_run(12'd5);
      for (int i = 0; i < 3; i++) beat(DW'(i));
      n = 0;
      while (!o_done && n < 200) begin
         tick();
         n++;
      end
      tests_run++; if (n !== 64) begin tests_failed++; $display("FAIL to_latency got %0d idle cycles want 64", n); end
      tests_run++; if ({o_timeout, o_pass, o_busy} !== 3'b100) begin tests_failed++; $display("FAIL to_flags got to/pass/busy=%b want 100", {o_timeout, o_pass, o_busy}); end
      tests_run++; if (o_rx_cnt !== 12'd3) begin tests_failed++; $display("FAIL to_rx got %0d want 3", o_rx_cnt); end
      tick();
   endtask

   task automatic test_overrun_zero();
      start_run(12'd0);
      tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL zero_busy got %b want 0", o_busy); end
      tests_run++; if ({o_rx_cnt, o_timeout} !== {12'd3, 1'b1}) begin tests_failed++; $display("FAIL zero_hold got rx=%0d to=%b want 3/1", o_rx_cnt, o_timeout); end
      beat(8'h55);
      tests_run++; if (o_overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_set got %b want 1", o_overrun); end
      tests_run++; if ({o_rx_cnt, o_err_cnt} !== {12'd3, 12'd0}) begin tests_failed++; $display("FAIL ovr_counts got rx=%0d err=%0d want 3/0", o_rx_cnt, o_err_cnt); end
      start_run(12'd4);
      tests_run++; if ({o_overrun, o_timeout, o_busy} !== 3'b001) begin tests_failed++; $display("FAIL ovr_clear got ovr/to/busy=%b want 001", {o_overrun, o_timeout, o_busy}); end
      tests_run++; if (o_rx_cnt !== 12'd0) begin tests_failed++; $display("FAIL ovr_rx_clear got %0d want 0", o_rx_cnt); end
      for (int i = 0; i < 4; i++) beat(DW'(i));
      tests_run++; if ({o_done, o_pass} !== 2'b11) begin tests_failed++; $display("FAIL ovr_run got done/pass=%b want 11", {o_done, o_pass}); end
      tick();
   endtask

   task automatic test_back_to_back();
      start_run(12'd3);
      for (int i = 0; i < 3; i++) beat(DW'(i));
      tests_run++; if (o_done !== 1'b1) begin tests_failed++; $display("FAIL b2b_done1 got %b want 1", o_done); end
      // Start and beat during REPORT: start ignored, beat flagged.
      i_start = 1'b1; i_cnt = 12'd2; i_valid = 1'b1; i_data = 8'h00;
      tick();
      tests_run++; if ({o_busy, o_overrun} !== 2'b01) begin tests_failed++; $display("FAIL b2b_report got busy/ovr=%b want 01", {o_busy, o_overrun}); end
      // Start in IDLE with a coinciding beat that must not be counted.
      tick();
      i_start = 1'b0; i_valid = 1'b0;
      tests_run++; if ({o_busy, o_overrun} !== 2'b11) begin tests_failed++; $display("FAIL b2b_start got busy/ovr=%b want 11", {o_busy, o_overrun}); end
      tests_run++; if (o_rx_cnt !== 12'd0) begin tests_failed++; $display("FAIL b2b_rx0 got %0d want 0", o_rx_cnt); end
      beat(8'h00);
      beat(8'h01);
      tests_run++; if ({o_done, o_pass, o_overrun} !== 3'b111) begin tests_failed++; $display("FAIL b2b_done2 got done/pass/ovr=%b want 111", {o_done, o_pass, o_overrun}); end
      tests_run++; if (o_rx_cnt !== 12'd2) begin tests_failed++; $display("FAIL b2b_rx got %0d want 2", o_rx_cnt); end
      tick();
   endtask

   task automatic test_reset_mid();
      logic saw_done;
      saw_done = 1'b0;
      start_run(12'd8);
      for (int i = 0; i < 4; i++) beat(DW'(i));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      if (o_done) saw_done = 1'b1;
      tests_run++; if ({o_busy, o_pass, o_timeout, o_overrun} !== 4'b0000) begin tests_failed++; $display("FAIL rstmid_flags got %b want 0000", {o_busy, o_pass, o_timeout, o_overrun}); end
      tests_run++; if ({o_rx_cnt, o_err_cnt} !== '0) begin tests_failed++; $display("FAIL rstmid_counts got rx=%0d err=%0d want 0/0", o_rx_cnt, o_err_cnt); end
      tick();
      if (o_done) saw_done = 1'b1;
      tests_run++; if (saw_done !== 1'b0) begin tests_failed++; $display("FAIL rstmid_nodone got %b want 0", saw_done); end
      start_run(12'd8);
      // Starts during CHECK must not re-arm the run.
      i_start = 1'b1; i_cnt = 12'd2;
      for (int i = 0; i < 8; i++) beat(DW'(i));
      i_start = 1'b0;
      tests_run++; if ({o_done, o_pass} !== 2'b11) begin tests_failed++; $display("FAIL rstmid_rerun got done/pass=%b want 11", {o_done, o_pass}); end
      tests_run++; if (o_rx_cnt !== 12'd8) begin tests_failed++; $display("FAIL rstmid_rx got %0d want 8", o_rx_cnt); end
      tick();
   endtask

   task automatic test_max_count();
      start_run('1);
      for (int i = 0; i < 4095; i++) beat(DW'(i % 256));
      tests_run++; if ({o_done, o_pass, o_timeout} !== 3'b110) begin tests_failed++; $display("FAIL max_flags got done/pass/to=%b want 110", {o_done, o_pass, o_timeout}); end
      tests_run++; if (o_rx_cnt !== 12'hFFF) begin tests_failed++; $display("FAIL max_rx got %0d want 4095", o_rx_cnt); end
      tick();
   endtask

   initial begin
      test_reset();
      test_clean();
      test_wrap_gaps();
      test_corruption();
      test_timeout();
      test_overrun_zero();
      test_back_to_back();
      test_reset_mid();
      test_max_count();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/bram_rdback_checker.md
# bram_rdback_checker

Downstream consumer of the BRAM controller's read-back stream. It is armed with the same operation count as the controller and accepts the `valid`/`data` beats produced during the READ phase. Each beat is compared against the write pattern (data = index mod 2^DATA_WIDTH), and the block counts beats and mismatches. At the end of a run it issues a one-cycle done pulse with a held pass/fail verdict, an overrun flag and a watchdog timeout flag.

## Interface
- `DATA_WIDTH`, 8: width of the read-back data beats.
- `ADDR_WIDTH`, 12: width of the count and index registers; matches the controller's address width.
- `TIMEOUT`, 64: maximum idle cycles between beats in CHECK before the run aborts; must be ≥ 2.

- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  arm the checker; sampled only in IDLE.
- `i_cnt`  in  ADDR_WIDTH  expected beat count, latched on an accepted start.
- `i_valid`  in  1  read-data beat strobe; the controller's delayed read-valid.
- `i_data`  in  DATA_WIDTH  read-data beat; the BRAM read output.
- `o_busy`  out  1  high in CHECK.
- `o_done`  out  1  one-cycle pulse in REPORT.
- `o_pass`  out  1  verdict; held until the next accepted start.
- `o_timeout`  out  1  watchdog fired in the last run; held.
- `o_overrun`  out  1  sticky; a beat arrived outside CHECK.
- `o_rx_cnt`  out  ADDR_WIDTH  beats accepted in the current or last run.
- `o_err_cnt`  out  ADDR_WIDTH  mismatching beats; saturates at all-ones.
- `o_ferr_vld`, `o_ferr_idx[ADDR_WIDTH]`, `o_ferr_data[DATA_WIDTH]`  out  first-error capture; present only with the macro enabled.

## Operation
- FSM states: IDLE → CHECK → REPORT → IDLE. Encoding is 2 bits; the unused code returns to IDLE.
- **IDLE**
  - `i_start && i_cnt != 0`: latch `r_cnt = i_cnt`; clear rx, err, timeout, overrun, pass and ferr; go to CHECK.
  - `i_start && i_cnt == 0`: ignored; stay in IDLE with all outputs unchanged.
- **CHECK**, for each cycle with `i_valid = 1`:
  - expected value = `o_rx_cnt[DATA_WIDTH-1:0]`, zero-extended when DATA_WIDTH > ADDR_WIDTH.
  - On mismatch, `o_err_cnt` increments, holding at all-ones.
  - `o_rx_cnt` increments. When the accepted beat has index `r_cnt-1`, go to REPORT.
- **Watchdog:** an idle counter clears on every beat and on entry to CHECK. When it reaches `TIMEOUT-1` with no beat, set `o_timeout` and go to REPORT.
- **REPORT** (one cycle): `o_done = 1`; `o_pass = (err_cnt == 0) && !timeout`, using the final counts. Next state is IDLE.
- **Overrun:** any `i_valid` in IDLE or REPORT sets `o_overrun`. The beat is otherwise dropped. This includes a beat in the same cycle as an accepted start; the start still proceeds and that beat is not counted.
- `i_start` in CHECK or REPORT is ignored.
- Counter width: `o_rx_cnt` never exceeds `r_cnt`. `i_cnt` of all-ones is legal.

## Timing
- **Reset** (`rst` high at a clock edge):
  - State = IDLE.
  - All outputs = 0: `o_busy`, `o_done`, `o_pass`, `o_timeout`, `o_overrun`, both counts and all ferr outputs.
  - Reset takes precedence over every other input. Reset asserted mid-CHECK aborts the run with no `o_done` pulse.
- **Start:** `o_busy` rises the cycle after an accepted `i_start`. A beat is accepted from that cycle onward.
- **Done latency:** `o_done` is high exactly one cycle, in the cycle after the last beat, or after the `TIMEOUT`-th idle cycle. `o_busy` is low in that cycle.
- **Verdict timing:** `o_pass`, `o_timeout`, `o_err_cnt` and `o_rx_cnt` are valid in the `o_done` cycle and held until the next accepted start.
- All outputs are registered; there is no combinational path from input to output.
- **Back-to-back runs:** the earliest next accepted start is in the cycle after REPORT, i.e. in IDLE.

## Configuration
- `BRAM_CHK_FIRST_ERR_EN` defined:
  - On the first mismatch of a run, capture the beat index into `o_ferr_idx` and the received data into `o_ferr_data`, and set `o_ferr_vld`.
  - Later mismatches do not update the capture.
  - The capture is cleared on an accepted start and held through REPORT and IDLE.
- `BRAM_CHK_FIRST_ERR_EN` undefined: the `o_ferr_*` ports and their registers are not generated. All other behaviour is identical.

## Test plan
- **Clean run:** `i_cnt = 100`; 100 beats of data 0..99, back-to-back → one `o_done` the cycle after beat 99; `o_pass = 1`, `o_rx_cnt = 100`, `o_err_cnt = 0`, `o_timeout = 0`.
- **Wrap and gaps:** `i_cnt = 300`, `DATA_WIDTH = 8`; data = index mod 256, with 1–3 idle cycles between beats → `o_pass = 1`, `o_rx_cnt = 300`, no timeout.
- **Corruption:** `i_cnt = 10`; beats 3 and 7 inverted → `o_err_cnt = 2`, `o_pass = 0`. With the macro: `o_ferr_idx = 3`, `o_ferr_data = 8'hFC`.
- **Timeout:** `i_cnt = 5`; only 3 beats, then silence → `o_done` after 64 idle cycles; `o_timeout = 1`, `o_pass = 0`, `o_rx_cnt = 3`.
- **Overrun and zero count:**
  - `i_start` with `i_cnt = 0` → stays in IDLE.
  - A beat while IDLE → `o_overrun = 1`, counts unchanged; a subsequent accepted start clears it.
- **Reset mid-run:** `rst` asserted after 4 of 8 beats → no `o_done`; all outputs 0 the next cycle. A fresh 8-beat run then passes.
